// File: rtl/vga_fb_scanout_if.sv
// rtl/vga_fb_scanout_if.sv - framebuffer read port and VGA pin bundle for the scanout block
interface vga_fb_scanout_if;
    logic [14:0] fb_rd_addr;
    logic [2:0]  fb_rd_data;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic        vga_clk;
    logic        frame_start;
    logic        in_vblank;

    modport master (
        output fb_rd_addr,
        input  fb_rd_data,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk,
        output frame_start, in_vblank
    );

    modport slave (
        input  fb_rd_addr,
        output fb_rd_data,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk,
        input  frame_start, in_vblank
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - 640x480 VGA timing and 4x4-upscaled framebuffer scanout
module vga_fb_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FB_W        = 160,
    parameter int SCALE_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_fb_scanout_if.master  io_bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] HC_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] VC_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_B    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_E    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_B    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        r_pix_en;
    logic        r_vga_clk;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic        r_active1;
    logic        r_hs1;
    logic        r_vs1;
    logic [14:0] r_addr;
    logic [2:0]  r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic        r_frame_start;
    logic        r_in_vblank;

    logic        w_hc_last;
    logic        w_vc_last;
    logic        w_active;
    logic        w_hs_pulse;
    logic        w_vs_pulse;
    logic [14:0] w_y;
    logic [14:0] w_x;
    logic [14:0] w_row;
    logic [14:0] w_addr;

    assign w_hc_last  = (r_hc == HC_LAST);
    assign w_vc_last  = (r_vc == VC_LAST);
    assign w_active   = (r_hc < H_ACT) && (r_vc < V_ACT);
    assign w_hs_pulse = (r_hc >= HS_B) && (r_hc <= HS_E);
    assign w_vs_pulse = (r_vc >= VS_B) && (r_vc <= VS_E);

    // Row base uses shift-add for the 160-wide buffer so no multiplier is built.
    assign w_y    = 15'(r_vc >> SCALE_SHIFT);
    assign w_x    = 15'(r_hc >> SCALE_SHIFT);
    assign w_row  = (FB_W == 160) ? (w_y << 7) + (w_y << 5) : w_y * 15'(FB_W);
    assign w_addr = w_row + w_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_en      <= 1'b0;
            r_vga_clk     <= 1'b0;
            r_frame_start <= 1'b0;
            r_hc          <= '0;
            r_vc          <= '0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_vga_clk     <= ~r_pix_en;
            r_frame_start <= r_pix_en && w_hc_last && w_vc_last;
            if (r_pix_en) begin
                r_hc <= w_hc_last ? '0 : r_hc + 10'd1;
                if (w_hc_last) begin
                    r_vc <= w_vc_last ? '0 : r_vc + 10'd1;
                end
            end
        end
    end

    // Stage 1 issues the read; stage 2 lands it one pixel tick later with matching sync/blank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active1   <= 1'b0;
            r_addr      <= '0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_in_vblank <= 1'b0;
            r_rgb       <= 3'b000;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_blank_n   <= 1'b0;
        end else if (r_pix_en) begin
            r_active1   <= w_active;
            r_addr      <= w_active ? w_addr : '0;
            r_hs1       <= ~w_hs_pulse;
            r_vs1       <= ~w_vs_pulse;
            r_in_vblank <= (r_vc >= V_ACT);
            r_rgb       <= r_active1 ? io_bus.fb_rd_data : 3'b000;
            r_hs        <= r_hs1;
            r_vs        <= r_vs1;
            r_blank_n   <= r_active1;
        end
    end

    assign io_bus.fb_rd_addr  = r_addr;
    assign io_bus.vga_r       = r_rgb[2];
    assign io_bus.vga_g       = r_rgb[1];
    assign io_bus.vga_b       = r_rgb[0];
    assign io_bus.vga_hs      = r_hs;
    assign io_bus.vga_vs      = r_vs;
    assign io_bus.vga_blank_n = r_blank_n;
    assign io_bus.vga_sync_n  = 1'b0;
    assign io_bus.vga_clk     = r_vga_clk;
    assign io_bus.frame_start = r_frame_start;
    assign io_bus.in_vblank   = r_in_vblank;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - scoreboard bench for vga_fb_scanout with a shortened vertical frame
module tb_vga_fb_scanout;
    localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACTIVE = 8, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_TOT = 800, V_TOT = 12, FB_W = 160;
    localparam int HS_B = 656, HS_E = 752;
    localparam int VS_B = V_ACTIVE + V_FP, VS_E = V_ACTIVE + V_FP + V_SYNC;
    localparam int FRAME_CLK = 2 * H_TOT * V_TOT;
    localparam logic [5:0] RST_PINS = 6'b000_110;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_force = 1'b1;
    int checks = 0;
    int failures = 0;

    vga_fb_scanout_if bus ();

    vga_fb_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FB_W(FB_W), .SCALE_SHIFT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk) bus.fb_rd_data <= mem_force ? 3'b111 : bus.fb_rd_addr[2:0];

    logic [5:0] dut_pins;
    assign dut_pins = {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.vga_blank_n};

    int m_hc, m_vc;
    bit m_pe, tick, exp_fs, exp_vb;
    logic [14:0] exp_addr;
    logic [5:0] exp_pins;
    logic [5:0] sbq[$];

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_pe = 1'b0; tick = 1'b0;
        exp_fs = 1'b0; exp_vb = 1'b0; exp_addr = '0;
        sbq.delete();
        sbq.push_back(RST_PINS);
        exp_pins = RST_PINS;
    endtask

    task automatic clk_step();
        bit act;
        int a;
        logic [2:0] d;
        @(posedge clk);
        #1;
        tick = m_pe;
        exp_fs = 1'b0;
        if (m_pe) begin
            act = (m_hc < H_ACTIVE) && (m_vc < V_ACTIVE);
            a = act ? (m_vc / 4) * FB_W + (m_hc / 4) : 0;
            exp_addr = 15'(a);
            d = mem_force ? 3'b111 : exp_addr[2:0];
            sbq.push_back({act ? d : 3'b000, !(m_hc >= HS_B && m_hc < HS_E),
                           !(m_vc >= VS_B && m_vc < VS_E), act});
            if (sbq.size() >= 2) exp_pins = sbq.pop_front();
            exp_vb = (m_vc >= V_ACTIVE);
            exp_fs = (m_hc == H_TOT - 1) && (m_vc == V_TOT - 1);
            if (m_hc == H_TOT - 1) begin
                m_hc = 0;
                m_vc = (m_vc == V_TOT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc = m_hc + 1;
            end
        end
        m_pe = !m_pe;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_force = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dut_pins !== RST_PINS) begin failures++; $display("FAIL reset_pins got=%b exp=%b", dut_pins, RST_PINS); end
        checks++; if (bus.fb_rd_addr !== 15'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.fb_rd_addr); end
        checks++; if (bus.frame_start !== 1'b0 || bus.in_vblank !== 1'b0) begin failures++; $display("FAIL reset_flags fs=%b vb=%b exp=0 0", bus.frame_start, bus.in_vblank); end
        checks++; if (bus.vga_clk !== 1'b0 || bus.vga_sync_n !== 1'b0) begin failures++; $display("FAIL reset_clk vga_clk=%b sync_n=%b exp=0 0", bus.vga_clk, bus.vga_sync_n); end
        rst = 1'b1;
        clk_step();
        checks++; if (bus.vga_clk !== 1'b1) begin failures++; $display("FAIL vga_clk_edge1 got=%b exp=1", bus.vga_clk); end
        mem_force = 1'b0;
        clk_step();
        checks++; if (bus.vga_clk !== 1'b0) begin failures++; $display("FAIL vga_clk_edge2 got=%b exp=0", bus.vga_clk); end
    endtask

    task automatic test_line_timing();
        int n, first_low, hs_cnt, bl_cnt, guard;
        guard = 0;
        while (!(m_hc == 0 && m_vc == 1 && !m_pe) && guard < 4000) begin clk_step(); guard++; end
        checks++; if (guard >= 4000) begin failures++; $display("FAIL line_sync timeout got=%0d exp<4000", guard); end
        n = 0; first_low = -1; hs_cnt = 0; bl_cnt = 0;
        while (n < H_TOT) begin
            clk_step();
            if (tick) begin
                n++;
                if (bus.vga_hs === 1'b0) begin
                    hs_cnt++;
                    if (first_low < 0) first_low = n;
                end
                if (bus.vga_blank_n === 1'b1) bl_cnt++;
            end
        end
        checks++; if (first_low != 658) begin failures++; $display("FAIL hs_start got=%0d exp=658", first_low); end
        checks++; if (hs_cnt != 96) begin failures++; $display("FAIL hs_width got=%0d exp=96", hs_cnt); end
        checks++; if (bl_cnt != 640) begin failures++; $display("FAIL blank_width got=%0d exp=640", bl_cnt); end
    endtask

    task automatic test_addressing();
        int pts_h[6] = '{5, 0, 4, 7, 639, 640};
        int pts_v[6] = '{3, 4, 4, 7, 7, 7};
        int pts_a[6] = '{1, 160, 161, 161, 319, 0};
        int guard;
        for (int i = 0; i < 6; i++) begin
            guard = 0;
            while (!(m_pe && m_hc == pts_h[i] && m_vc == pts_v[i]) && guard < 12000) begin clk_step(); guard++; end
            clk_step();
            checks++;
            if (guard >= 12000 || bus.fb_rd_addr !== 15'(pts_a[i])) begin
                failures++;
                $display("FAIL addr hc=%0d vc=%0d got=%0d exp=%0d", pts_h[i], pts_v[i], bus.fb_rd_addr, pts_a[i]);
            end
        end
    endtask

    task automatic test_frame_timing();
        int guard, fs_cnt, last_fs, vs_cnt, vb_cnt;
        guard = 0;
        while (bus.frame_start !== 1'b1 && guard < 2 * FRAME_CLK) begin clk_step(); guard++; end
        checks++; if (guard >= 2 * FRAME_CLK || !exp_fs) begin failures++; $display("FAIL fs_first got=%b exp=1 model=%b", bus.frame_start, exp_fs); end
        fs_cnt = 0; last_fs = 0; vs_cnt = 0; vb_cnt = 0;
        for (int i = 1; i <= FRAME_CLK; i++) begin
            clk_step();
            checks++; if (bus.frame_start !== exp_fs) begin failures++; $display("FAIL fs_clk i=%0d got=%b exp=%b", i, bus.frame_start, exp_fs); end
            if (bus.frame_start === 1'b1) begin fs_cnt++; last_fs = i; end
            if (tick) begin
                checks++; if (dut_pins !== exp_pins) begin failures++; $display("FAIL frame_pins i=%0d got=%b exp=%b", i, dut_pins, exp_pins); end
                checks++; if (bus.fb_rd_addr !== exp_addr) begin failures++; $display("FAIL frame_addr i=%0d got=%0d exp=%0d", i, bus.fb_rd_addr, exp_addr); end
                checks++; if (bus.in_vblank !== exp_vb) begin failures++; $display("FAIL frame_vblank i=%0d got=%b exp=%b", i, bus.in_vblank, exp_vb); end
                if (bus.vga_vs === 1'b0) vs_cnt++;
                if (bus.in_vblank === 1'b1) vb_cnt++;
            end
        end
        checks++; if (fs_cnt != 1 || last_fs != FRAME_CLK) begin failures++; $display("FAIL fs_period count=%0d at=%0d exp=1 at %0d", fs_cnt, last_fs, FRAME_CLK); end
        clk_step();
        checks++; if (bus.frame_start !== 1'b0) begin failures++; $display("FAIL fs_width got=%b exp=0", bus.frame_start); end
        checks++; if (vs_cnt != V_SYNC * H_TOT) begin failures++; $display("FAIL vs_width got=%0d exp=%0d", vs_cnt, V_SYNC * H_TOT); end
        checks++; if (vb_cnt != (V_TOT - V_ACTIVE) * H_TOT) begin failures++; $display("FAIL vblank_len got=%0d exp=%0d", vb_cnt, (V_TOT - V_ACTIVE) * H_TOT); end
    endtask

    task automatic test_blanking();
        int n;
        while (!m_pe) clk_step();
        mem_force = 1'b1;
        n = 0;
        while (n < 6 * H_TOT) begin
            clk_step();
            if (tick) begin
                n++;
                checks++; if (dut_pins !== exp_pins) begin failures++; $display("FAIL blank_pins n=%0d got=%b exp=%b", n, dut_pins, exp_pins); end
            end
        end
        while (!m_pe) clk_step();
        mem_force = 1'b0;
    endtask

    task automatic test_mid_reset();
        int guard, first_low;
        guard = 0;
        while (!(m_pe && m_hc == 300 && m_vc == 6) && guard < 2 * FRAME_CLK) begin clk_step(); guard++; end
        clk_step();
        rst = 1'b0;
        #1;
        checks++; if (guard >= 2 * FRAME_CLK || dut_pins !== RST_PINS) begin failures++; $display("FAIL midrst_pins got=%b exp=%b", dut_pins, RST_PINS); end
        checks++; if (bus.fb_rd_addr !== 15'd0 || bus.in_vblank !== 1'b0 || bus.vga_clk !== 1'b0) begin failures++; $display("FAIL midrst_state addr=%0d vb=%b vclk=%b exp=0", bus.fb_rd_addr, bus.in_vblank, bus.vga_clk); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        first_low = -1;
        for (int i = 1; i <= 1400; i++) begin
            clk_step();
            if (tick) begin
                checks++; if (dut_pins !== exp_pins) begin failures++; $display("FAIL midrst_scan i=%0d got=%b exp=%b", i, dut_pins, exp_pins); end
            end
            if (first_low < 0 && bus.vga_hs === 1'b0) first_low = i;
        end
        checks++; if (first_low != 1316) begin failures++; $display("FAIL midrst_hs_pos got=%0d exp=1316", first_low); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_addressing();
        test_frame_timing();
        test_blanking();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Display-side reader of the 160x120, 3-bit-colour framebuffer that the game FSM writes through its x/y/colour/plot port.
- Generates 640x480@60 Hz VGA timing from the 50 MHz board clock.
- Fetches framebuffer words with 1-clk read latency and upscales each stored pixel 4x4.
- Drives the VGA DAC pins and gives the game FSM frame_start and in_vblank, so it can update paddles and ball once per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (H total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (V total 525)
- FB_W, 160, framebuffer width (pixels per row)
- SCALE_SHIFT, 2, log2 of the upscale factor

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous reset, active-low
- fb_rd_addr  out  15  framebuffer read address, y*160+x
- fb_rd_data  in  3  {R,G,B} word; valid 1 clk after fb_rd_addr
- vga_r  out  1  red
- vga_g  out  1  green
- vga_b  out  1  blue
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  high during the visible region
- vga_sync_n  out  1  tied 0
- vga_clk  out  1  25 MHz pixel clock to the DAC
- frame_start  out  1  one-clk pulse at the start of each frame
- in_vblank  out  1  high while vc >= V_ACTIVE

Behaviour:
- Reset (rst=0, asynchronous):
  - pix_en=0, hc=0, vc=0, all pipeline registers cleared.
  - fb_rd_addr=0, rgb=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_clk=0, frame_start=0, in_vblank=0.
- Pixel enable:
  - pix_en toggles every clk, so it is high on every second clk; 1 pixel tick = 2 clk.
  - vga_clk is the registered inverse of pix_en, so its rising edge falls mid-way through each output pixel.
- Counters:
  - hc 0..799 and vc 0..524 advance only on pix_en.
  - hc wraps 799->0 and increments vc; vc wraps 524->0 when hc wraps.
- Stage 1 (pix_en tick, sampling pre-increment hc/vc):
  - active1 = (hc<640 && vc<480).
  - fb_rd_addr <= active1 ? (vc>>2)*160 + (hc>>2) : 0; compute the multiply as (y<<7)+(y<<5)+x.
  - hs1 = !(hc in 656..751); vs1 = !(vc in 490..491).
- Memory: fb_rd_data is valid during the following non-pix_en clk.
- Stage 2 (next pix_en tick):
  - {vga_r,vga_g,vga_b} <= active1 ? fb_rd_data : 3'b000.
  - vga_hs <= hs1, vga_vs <= vs1, vga_blank_n <= active1.
- Latency: pins show pixel (hc,vc) exactly 2 pixel ticks (4 clk) after the counters held it. RGB, sync and blank stay mutually aligned.
- Address range:
  - Max address 19199 at (639,479).
  - Each address is presented for 4 consecutive pixel ticks and for 4 consecutive lines.
- frame_start: high for exactly 1 clk on the pix_en tick where the counters move from (799,524) to (0,0). Not asserted at the first tick after reset.
- in_vblank: registered; updates on the pix_en tick, high for vc 480..524.
- Blanking: RGB is forced to 0 outside the active region regardless of fb_rd_data.
- Reset mid-frame: all state returns to reset values immediately. Scan restarts at (0,0) with no partial sync pulse carried over.

Test Plan:
- Reset check: hold rst=0 with fb_rd_data=3'b111. Required: rgb=0, hs=vs=1, blank_n=0, fb_rd_addr=0, frame_start=0. After release, the first pix_en occurs on the 2nd clk.
- Line timing: run one line. Required: vga_hs low for exactly 96 pixel ticks (192 clk), beginning 658 ticks after the hc=0 tick; vga_blank_n high for exactly 640 ticks per line.
- Addressing: at hc=4,vc=4 require fb_rd_addr=161; at hc=7,vc=7 require 161; at hc=639,vc=479 require 19199; at hc=640 require 0.
- Data path with a memory model (addr[2:0] returned as data): visible RGB matches 2 ticks later. With data forced to 3'b111 during blanking, RGB stays 0 during blanking.
- Frame timing: frame_start pulses every 420000 pixel ticks (840000 clk), each 1 clk wide. vga_vs is low for 2 lines (1600 ticks). in_vblank is high for 45 lines.
- Mid-frame reset: assert rst at hc=300,vc=200 for 3 clk. Required: all outputs return to reset values at once. After release, the next line's HS pulse appears at the normal position measured from (0,0).
